// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table and monitor types; the counter's encoder uses the same constants.
package seg7_pkg;

  typedef logic [7:0] seg7_t;

  typedef enum logic [1:0] {
    SETTLE,
    CHECK,
    HOLD
  } mon_state_t;

  // Active-low segments, bit order g..a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational glyph-to-digit decode; flags unknown glyphs and digits outside the radix.
module seg7_digit_decode
  import seg7_pkg::*;
#(
  parameter int P_BASE_NUMBER = 7
) (
  input  seg7_t      hex,
  output logic [3:0] digit,
  output logic       illegal
);

  localparam logic [3:0] BASE = 4'(P_BASE_NUMBER);

  logic       unused_dp;
  logic [3:0] raw;
  logic       bad_glyph;

  assign unused_dp = hex[7];

  always_comb begin
    raw       = 4'd0;
    bad_glyph = 1'b0;
    case (hex[6:0])
      SEG_0, SEG_BLANK: raw = 4'd0;
      SEG_1:            raw = 4'd1;
      SEG_2:            raw = 4'd2;
      SEG_3:            raw = 4'd3;
      SEG_4:            raw = 4'd4;
      SEG_5:            raw = 4'd5;
      SEG_6:            raw = 4'd6;
      SEG_7:            raw = 4'd7;
      SEG_8:            raw = 4'd8;
      SEG_9:            raw = 4'd9;
      default:          bad_glyph = 1'b1;
    endcase
  end

  // Digits the counter can never show in this radix are treated like bad glyphs.
  assign illegal = bad_glyph | (raw >= BASE);
  assign digit   = illegal ? 4'd0 : raw;

endmodule

// File: rtl/seg7_count_monitor.sv
// Reads back a two-digit base-N 7-segment display, debounces it, reports each new
// settled value once and classifies the transition as step, wrap or jump.
module seg7_count_monitor
  import seg7_pkg::*;
#(
  parameter int P_BASE_NUMBER   = 7,
  parameter int P_STABLE_CYCLES = 16
) (
  input  logic       CLK1,
  input  logic       RST,
  input  logic [7:0] HEX0,
  input  logic [7:0] HEX1,
  output logic [6:0] VALUE,
  output logic [3:0] DIGIT0,
  output logic [3:0] DIGIT1,
  output logic       VALID,
  output logic       STEP,
  output logic       WRAP,
  output logic       JUMP_ERR,
  output logic       PAT_ERR
);

  localparam int            CW       = $clog2(P_STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(P_STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_TRIG = CW'(P_STABLE_CYCLES - 1);
  localparam logic [6:0]    BASE7    = 7'(P_BASE_NUMBER);
  localparam logic [6:0]    WRAP_VAL = 7'(P_BASE_NUMBER * P_BASE_NUMBER - 1);

  mon_state_t    state, state_nxt;
  logic [15:0]   smp, prev, held, last_raw;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          first;

  logic [3:0]    d0, d1;
  logic          ill0, ill1, new_ill;
  logic [6:0]    new_val;
  logic          differs, step_c, wrap_c, jump_c;

  // While in CHECK, prev always holds the settled pattern even if smp has moved on.
  seg7_digit_decode #(.P_BASE_NUMBER(P_BASE_NUMBER)) u_dec0 (
    .hex(prev[7:0]), .digit(d0), .illegal(ill0)
  );
  seg7_digit_decode #(.P_BASE_NUMBER(P_BASE_NUMBER)) u_dec1 (
    .hex(prev[15:8]), .digit(d1), .illegal(ill1)
  );

  assign new_ill = ill0 | ill1;
  assign new_val = new_ill ? 7'd0 : (7'(d1) * BASE7 + 7'(d0));

  // Legal patterns compare by value (DP ignored); illegal ones compare raw.
  assign differs = first | (new_ill != PAT_ERR) |
                   (new_ill ? (prev != last_raw) : (new_val != VALUE));

  assign step_c = ~first & ~new_ill & ~PAT_ERR & (new_val == VALUE + 7'd1);
  assign wrap_c = ~first & ~new_ill & ~PAT_ERR & (VALUE == WRAP_VAL) & (new_val == 7'd0);
  assign jump_c = ~first & ~step_c & ~wrap_c;

  always_comb begin
    cnt_nxt = cnt;
    if (smp != prev)          cnt_nxt = '0;
    else if (cnt != CNT_MAX)  cnt_nxt = cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE: if (smp == prev && cnt_nxt == CNT_TRIG) state_nxt = CHECK;
      CHECK:  state_nxt = HOLD;
      // held catches a change that landed during CHECK and already reached prev.
      HOLD:   if (smp != prev || smp != held) state_nxt = SETTLE;
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge CLK1) begin
    if (RST) state <= SETTLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK1) begin
    if (RST) begin
      smp      <= 16'hFFFF;
      prev     <= 16'hFFFF;
      held     <= 16'hFFFF;
      last_raw <= 16'hFFFF;
      cnt      <= '0;
      first    <= 1'b1;
      VALUE    <= 7'd0;
      DIGIT0   <= 4'd0;
      DIGIT1   <= 4'd0;
      VALID    <= 1'b0;
      STEP     <= 1'b0;
      WRAP     <= 1'b0;
      JUMP_ERR <= 1'b0;
      PAT_ERR  <= 1'b0;
    end else begin
      smp      <= {HEX1, HEX0};
      prev     <= smp;
      cnt      <= cnt_nxt;
      VALID    <= 1'b0;
      STEP     <= 1'b0;
      WRAP     <= 1'b0;
      JUMP_ERR <= 1'b0;
      if (state == CHECK) begin
        held <= prev;
        if (differs) begin
          VALID    <= 1'b1;
          STEP     <= step_c;
          WRAP     <= wrap_c;
          JUMP_ERR <= jump_c;
          VALUE    <= new_val;
          DIGIT0   <= new_ill ? 4'd0 : d0;
          DIGIT1   <= new_ill ? 4'd0 : d1;
          PAT_ERR  <= new_ill;
          last_raw <= prev;
          first    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Bench for seg7_count_monitor: directed scenarios plus random display traffic against a run-length model.
module tb_seg7_count_monitor;

  localparam int B = 7;
  localparam int S = 16;

  logic       CLK1 = 1'b0;
  logic       RST;
  logic [7:0] HEX0, HEX1;
  logic [6:0] VALUE;
  logic [3:0] DIGIT0, DIGIT1;
  logic       VALID, STEP, WRAP, JUMP_ERR, PAT_ERR;

  seg7_count_monitor #(.P_BASE_NUMBER(B), .P_STABLE_CYCLES(S)) dut (
    .CLK1(CLK1), .RST(RST), .HEX0(HEX0), .HEX1(HEX1),
    .VALUE(VALUE), .DIGIT0(DIGIT0), .DIGIT1(DIGIT1),
    .VALID(VALID), .STEP(STEP), .WRAP(WRAP), .JUMP_ERR(JUMP_ERR), .PAT_ERR(PAT_ERR)
  );

  always #10 CLK1 = ~CLK1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] glyph   [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] ill_pat [4]  = '{8'hAA, 8'hD5, 8'hF8, 8'h90};

  // Model: a pattern seen on S consecutive edges settles; a differing settle is reported two edges later.
  int          cyc = 0;
  logic [15:0] run_pat;
  int          run_len;
  bit          pend;
  int          pend_due;
  bit          p_step, p_wrap, p_jump, p_ill;
  int          p_val, p_d0, p_d1;
  bit          r_first, r_ill;
  int          r_val;
  logic [15:0] r_raw;
  logic [4:0]  e_flags;   // {VALID,STEP,WRAP,JUMP_ERR,PAT_ERR}
  logic [14:0] e_outs;    // {VALUE,DIGIT1,DIGIT0}
  bit          e_pat;

  function automatic void dec(input logic [7:0] h, output int d, output bit ok);
    ok = 0;
    d  = 0;
    if (h[6:0] == 7'h7F) ok = 1;
    for (int i = 0; i < 10; i++)
      if (h[6:0] == glyph[i][6:0]) begin ok = 1; d = i; end
    if (d >= B) begin ok = 0; d = 0; end
  endfunction

  task automatic settle();
    int d0, d1, v;
    bit ok0, ok1, ill, diff;
    dec(run_pat[7:0], d0, ok0);
    dec(run_pat[15:8], d1, ok1);
    ill = !(ok0 && ok1);
    if (ill) begin d0 = 0; d1 = 0; end
    v = d1 * B + d0;
    diff = r_first || (ill != r_ill) || (ill ? (run_pat != r_raw) : (v != r_val));
    if (diff) begin
      p_step   = !r_first && !ill && !r_ill && (v == r_val + 1);
      p_wrap   = !r_first && !ill && !r_ill && (r_val == B * B - 1) && (v == 0);
      p_jump   = !r_first && !p_step && !p_wrap;
      p_ill    = ill;
      p_val    = v;
      p_d0     = d0;
      p_d1     = d1;
      pend     = 1;
      pend_due = cyc + 2;
      r_first  = 0;
      r_ill    = ill;
      r_val    = v;
      r_raw    = run_pat;
    end
  endtask

  task automatic tick();
    @(posedge CLK1);
    cyc++;
    e_flags[4:1] = 4'b0;
    if (RST) begin
      run_pat = 16'hFFFF;
      run_len = 2;
      pend    = 0;
      r_first = 1;
      r_ill   = 0;
      r_val   = 0;
      r_raw   = 16'hFFFF;
      e_flags = 5'b0;
      e_outs  = 15'b0;
    end else begin
      if (pend && pend_due == cyc) begin
        e_flags = {1'b1, p_step, p_wrap, p_jump, p_ill};
        e_outs  = {7'(p_val), 4'(p_d1), 4'(p_d0)};
        pend    = 0;
      end
      if ({HEX1, HEX0} == run_pat) begin
        if (run_len <= S) run_len++;
      end else begin
        run_pat = {HEX1, HEX0};
        run_len = 1;
      end
      if (run_len == S) settle();
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; HEX1 = 8'hC0; HEX0 = 8'hC0;
    repeat (3) tick();
    n_chk++;
    if ({VALUE, DIGIT1, DIGIT0, VALID, STEP, WRAP, JUMP_ERR, PAT_ERR} !== 20'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=00000", {VALUE, DIGIT1, DIGIT0, VALID, STEP, WRAP, JUMP_ERR, PAT_ERR});
    end
    RST = 1'b0;
  endtask

  task automatic test_first_report();
    int nv = 0, at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_chk++;
      if ({VALID, STEP, WRAP, JUMP_ERR, PAT_ERR} !== e_flags) begin
        n_fail++; $display("FAIL first_flags cyc=%0d got=%b want=%b", cyc, {VALID, STEP, WRAP, JUMP_ERR, PAT_ERR}, e_flags);
      end
      n_chk++;
      if ({VALUE, DIGIT1, DIGIT0} !== e_outs) begin
        n_fail++; $display("FAIL first_value cyc=%0d got=%h want=%h", cyc, {VALUE, DIGIT1, DIGIT0}, e_outs);
      end
      if (VALID === 1'b1) begin nv++; if (at < 0) at = i; end
    end
    n_chk++;
    if (nv != 1) begin n_fail++; $display("FAIL first_pulse_count got=%0d want=1", nv); end
    n_chk++;
    if (at != S + 2) begin n_fail++; $display("FAIL first_latency got=%0d want=%0d", at, S + 2); end
  endtask

  task automatic test_count_sequence();
    int idx = 0;
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    for (int s = 0; s < 8; s++) begin
      HEX1 = (s == 7) ? glyph[1] : glyph[0];
      HEX0 = (s == 7) ? glyph[0] : glyph[s];
      repeat (40) begin
        tick();
        n_chk++;
        if ({VALID, STEP, WRAP, JUMP_ERR, PAT_ERR} !== e_flags) begin
          n_fail++; $display("FAIL count_flags cyc=%0d got=%b want=%b", cyc, {VALID, STEP, WRAP, JUMP_ERR, PAT_ERR}, e_flags);
        end
        n_chk++;
        if ({VALUE, DIGIT1, DIGIT0} !== e_outs) begin
          n_fail++; $display("FAIL count_value cyc=%0d got=%h want=%h", cyc, {VALUE, DIGIT1, DIGIT0}, e_outs);
        end
        if (VALID === 1'b1) begin
          n_chk++;
          if (VALUE !== 7'(idx) || STEP !== (idx > 0)) begin
            n_fail++; $display("FAIL count_order got=%0d/%b want=%0d/%b", VALUE, STEP, idx, idx > 0);
          end
          idx++;
        end
      end
    end
    n_chk++;
    if (idx != 8) begin n_fail++; $display("FAIL count_reports got=%0d want=8", idx); end
  endtask

  task automatic test_wrap_jump();
    logic [7:0] h1s [3] = '{8'h82, 8'hC0, 8'h99};
    logic [7:0] h0s [3] = '{8'h82, 8'hC0, 8'hC0};
    logic [7:0] want [3] = '{{1'b1, 7'd48}, {1'b0, 7'd0}, {1'b1, 7'd28}};  // {jump, value}
    bit saw_wrap = 0;
    for (int s = 0; s < 3; s++) begin
      HEX1 = h1s[s]; HEX0 = h0s[s];
      repeat (40) begin
        tick();
        n_chk++;
        if ({VALID, STEP, WRAP, JUMP_ERR, PAT_ERR} !== e_flags) begin
          n_fail++; $display("FAIL wrap_flags cyc=%0d got=%b want=%b", cyc, {VALID, STEP, WRAP, JUMP_ERR, PAT_ERR}, e_flags);
        end
        n_chk++;
        if ({VALUE, DIGIT1, DIGIT0} !== e_outs) begin
          n_fail++; $display("FAIL wrap_value cyc=%0d got=%h want=%h", cyc, {VALUE, DIGIT1, DIGIT0}, e_outs);
        end
        if (VALID === 1'b1) begin
          n_chk++;
          if ({JUMP_ERR, VALUE} !== want[s]) begin
            n_fail++; $display("FAIL wrap_jump_report got=%h want=%h", {JUMP_ERR, VALUE}, want[s]);
          end
          if (WRAP === 1'b1) saw_wrap = 1;
        end
      end
    end
    n_chk++;
    if (!saw_wrap) begin n_fail++; $display("FAIL wrap_seen got=0 want=1"); end
  endtask

  task automatic test_glitch_illegal();
    int nv_glitch = 0;
    bit saw_err = 0;
    HEX1 = 8'hC0; HEX0 = 8'hA4;
    for (int s = 0; s < 4; s++) begin
      if (s == 1) HEX0 = 8'hB0;
      if (s == 2) HEX0 = 8'hA4;
      if (s == 3) HEX0 = 8'hF8;
      repeat ((s == 1) ? 5 : 40) begin
        tick();
        n_chk++;
        if ({VALID, STEP, WRAP, JUMP_ERR, PAT_ERR} !== e_flags) begin
          n_fail++; $display("FAIL glitch_flags cyc=%0d got=%b want=%b", cyc, {VALID, STEP, WRAP, JUMP_ERR, PAT_ERR}, e_flags);
        end
        n_chk++;
        if ({VALUE, DIGIT1, DIGIT0} !== e_outs) begin
          n_fail++; $display("FAIL glitch_value cyc=%0d got=%h want=%h", cyc, {VALUE, DIGIT1, DIGIT0}, e_outs);
        end
        if (VALID === 1'b1 && (s == 1 || s == 2)) nv_glitch++;
        if (VALID === 1'b1 && s == 3 && PAT_ERR === 1'b1 && JUMP_ERR === 1'b1 && VALUE === 7'd0) saw_err = 1;
      end
    end
    n_chk++;
    if (nv_glitch != 0) begin n_fail++; $display("FAIL glitch_pulses got=%0d want=0", nv_glitch); end
    n_chk++;
    if (!saw_err) begin n_fail++; $display("FAIL illegal_digit_report got=0 want=1"); end
  endtask

  task automatic test_reset_midsettle();
    int at = -1;
    HEX1 = 8'hC0; HEX0 = 8'hF9;
    for (int i = 0; i < 8 + 3 + 40; i++) begin
      RST = (i >= 8 && i < 11);
      tick();
      n_chk++;
      if ({VALID, STEP, WRAP, JUMP_ERR, PAT_ERR} !== e_flags) begin
        n_fail++; $display("FAIL rstmid_flags cyc=%0d got=%b want=%b", cyc, {VALID, STEP, WRAP, JUMP_ERR, PAT_ERR}, e_flags);
      end
      n_chk++;
      if ({VALUE, DIGIT1, DIGIT0} !== e_outs) begin
        n_fail++; $display("FAIL rstmid_value cyc=%0d got=%h want=%h", cyc, {VALUE, DIGIT1, DIGIT0}, e_outs);
      end
      if (i == 11 || i == 12) begin
        n_chk++;
        if ({VALUE, VALID, PAT_ERR} !== 9'b0) begin
          n_fail++; $display("FAIL rstmid_cleared got=%h want=000", {VALUE, VALID, PAT_ERR});
        end
      end
      if (VALID === 1'b1 && at < 0) at = i - 10;
    end
    RST = 1'b0;
    n_chk++;
    if (at != S + 2) begin n_fail++; $display("FAIL rstmid_latency got=%0d want=%0d", at, S + 2); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 90; seg++) begin
      int m, v, len;
      m = $urandom_range(0, 9);
      v = $urandom_range(0, B * B - 1);
      if (m < 5) v = (r_val + 1) % (B * B);
      HEX1 = glyph[v / B];
      HEX0 = glyph[v % B];
      if (m == 6 && v < B) HEX1 = 8'hFF;
      if (m == 7) HEX0 = ill_pat[$urandom_range(0, 3)];
      if (m == 8) HEX1[7] = 1'b0;
      len = (m == 9) ? $urandom_range(1, S - 1) : $urandom_range(S, S + 10);
      repeat (len) begin
        tick();
        n_chk++;
        if ({VALID, STEP, WRAP, JUMP_ERR, PAT_ERR} !== e_flags) begin
          n_fail++; $display("FAIL random_flags cyc=%0d got=%b want=%b", cyc, {VALID, STEP, WRAP, JUMP_ERR, PAT_ERR}, e_flags);
        end
        n_chk++;
        if ({VALUE, DIGIT1, DIGIT0} !== e_outs) begin
          n_fail++; $display("FAIL random_value cyc=%0d got=%h want=%h", cyc, {VALUE, DIGIT1, DIGIT0}, e_outs);
        end
      end
    end
  endtask

  initial begin
    e_flags = 5'b0;
    e_outs  = 15'b0;
    test_reset();
    test_first_report();
    test_count_sequence();
    test_wrap_jump();
    test_glitch_illegal();
    test_reset_midsettle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
